// File: rtl/rvfi_pkg.sv
// Shared RVFI retire record type, order width and the drain-side normalisation rule.
package rvfi_pkg;
  localparam int ORDER_W = 64;

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_pkt_t;

  // x0 traffic carries no information, so its data fields are zeroed for the monitor.
  function automatic rvfi_pkt_t rvfi_normalise(input rvfi_pkt_t p);
    rvfi_pkt_t r;
    r = p;
    if (p.rd_addr == 5'd0) r.rd_wdata = '0;
    if (p.rs1_addr == 5'd0) r.rs1_rdata = '0;
    if (p.rs2_addr == 5'd0) r.rs2_rdata = '0;
    return r;
  endfunction
endpackage

// File: rtl/rvfi_commit_packer_fifo.sv
// Multi-write / multi-read circular buffer; callers pass contiguous push and pop counts.
module rvfi_mwmr_fifo
  import rvfi_pkg::*;
#(
  parameter int W_PORTS = 2,
  parameter int R_PORTS = 8,
  parameter int DEPTH   = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CW-1:0]             push_n,
  input  rvfi_pkt_t [W_PORTS-1:0]   wr_data,
  input  logic [CW-1:0]             pop_n,
  output rvfi_pkt_t [R_PORTS-1:0]   rd_data,
  output logic [CW-1:0]             count
);
  rvfi_pkt_t     mem_q [DEPTH];
  rvfi_pkt_t     mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  always_comb begin
    mem_d  = mem_q;
    wr_idx = wr_ptr_q;
    for (int i = 0; i < W_PORTS; i++) begin
      wr_idx = wr_ptr_q + AW'(i);
      if (CW'(i) < push_n) mem_d[wr_idx] = wr_data[i];
    end
    // Pointer arithmetic wraps naturally in AW bits; a full-depth pop maps to +0.
    wr_ptr_d = wr_ptr_q + push_n[AW-1:0];
    rd_ptr_d = rd_ptr_q + pop_n[AW-1:0];
    count_d  = count_q + push_n - pop_n;
  end

  always_comb begin
    rd_idx = rd_ptr_q;
    for (int r = 0; r < R_PORTS; r++) begin
      rd_idx     = rd_ptr_q + AW'(r);
      rd_data[r] = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
endmodule

// File: rtl/rvfi_commit_packer.sv
// Packs multi-port RVFI retire groups into a buffer and drains them, normalised and
// order-stamped, onto monitor channels.
module rvfi_commit_packer
  import rvfi_pkg::*;
#(
  parameter int IN_W      = 2,
  parameter int DEPTH     = 16,
  parameter int OUT_CH    = 8,
  parameter int DRAIN_MAX = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [IN_W-1:0]                in_valid,
  input  rvfi_pkt_t [IN_W-1:0]           in_pkt,
  output logic                           in_ready,
  input  logic                           out_stall,
  output logic [OUT_CH-1:0]              out_valid,
  output logic [OUT_CH-1:0][ORDER_W-1:0] out_order,
  output rvfi_pkt_t [OUT_CH-1:0]         out_pkt,
  output logic [CW-1:0]                  count,
  output logic                           err
);
  logic [CW-1:0]                  fifo_count;
  logic [CW-1:0]                  push_n;
  logic [CW-1:0]                  pop_n;
  rvfi_pkt_t [DRAIN_MAX-1:0]      fifo_rd;
  logic                           contig;
  logic [ORDER_W-1:0]             order_q, order_d;
  logic                           err_q, err_d;
  logic [OUT_CH-1:0]              out_valid_q, out_valid_d;
  logic [OUT_CH-1:0][ORDER_W-1:0] out_order_q, out_order_d;
  rvfi_pkt_t [OUT_CH-1:0]         out_pkt_q, out_pkt_d;

  rvfi_mwmr_fifo #(
    .W_PORTS (IN_W),
    .R_PORTS (DRAIN_MAX),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_n  (push_n),
    .wr_data (in_pkt),
    .pop_n   (pop_n),
    .rd_data (fifo_rd),
    .count   (fifo_count)
  );

  // Only registered occupancy feeds in_ready, so it has no path from the inputs.
  assign in_ready = ~rst && ((CW'(DEPTH) - fifo_count) >= CW'(IN_W));
  assign contig   = (in_valid & (in_valid + IN_W'(1))) == '0;

  always_comb begin
    push_n = '0;
    if (in_ready && contig) begin
      for (int i = 0; i < IN_W; i++) push_n = push_n + CW'(in_valid[i]);
    end
    pop_n = '0;
    if (!out_stall) pop_n = (fifo_count > CW'(DRAIN_MAX)) ? CW'(DRAIN_MAX) : fifo_count;
    err_d = err_q | (in_ready & ~contig);
  end

  always_comb begin
    out_valid_d = '0;
    out_order_d = '0;
    out_pkt_d   = '0;
    for (int d = 0; d < DRAIN_MAX; d++) begin
      if (CW'(d) < pop_n) begin
        out_valid_d[d] = 1'b1;
        out_order_d[d] = order_q + ORDER_W'(d);
        out_pkt_d[d]   = rvfi_normalise(fifo_rd[d]);
      end
    end
    order_d = order_q + ORDER_W'(pop_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      order_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= '0;
      out_order_q <= '0;
      out_pkt_q   <= '0;
    end else begin
      order_q     <= order_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_order_q <= out_order_d;
      out_pkt_q   <= out_pkt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_order = out_order_q;
  assign out_pkt   = out_pkt_q;
  assign count     = fifo_count;
  assign err       = err_q;
endmodule

// File: doc/rvfi_commit_packer.md
RVFI_COMMIT_PACKER -- requirements
Module: rvfi_commit_packer

Interface
REQ-001 SHALL have parameters: IN_W, default 2, number of retire ports; DEPTH, default 16 (power of two, >= 2*IN_W), buffer entries; OUT_CH, default 8, monitor channels; DRAIN_MAX, default 8 (1..OUT_CH), maximum records emitted per cycle.
REQ-002 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: in_valid  in  IN_W  per-port retire valid; in_pkt  in  IN_W x rvfi_pkt_t  retire records, program order lowest port first.
REQ-004 SHALL have port: in_ready  out  1  whole retire group accepted this cycle.
REQ-005 SHALL have port: out_stall  in  1  bench backpressure, inhibits drain.
REQ-006 SHALL have ports: out_valid  out  OUT_CH  channel valid; out_order  out  OUT_CH x 64  retire order; out_pkt  out  OUT_CH x rvfi_pkt_t  channel record.
REQ-007 SHALL have ports: count  out  log2(DEPTH)+1  occupancy; err  out  1  sticky protocol error.

Function
REQ-008 in_ready SHALL be 1 iff DEPTH - count >= IN_W, computed from registered state only (no path from out_stall or in_valid).
REQ-009 When in_ready=1, all valid ports SHALL be written at the edge in port order; when in_ready=0, inputs SHALL be ignored.
REQ-010 in_valid SHALL be contiguous from port 0; a set bit above a clear bit SHALL set err and the group SHALL be dropped.
REQ-011 Each cycle with out_stall=0, n = min(count, DRAIN_MAX) oldest entries SHALL be popped at the edge and registered onto channels 0..n-1 with out_valid set; channels n..OUT_CH-1 SHALL have out_valid=0.
REQ-012 When out_stall=1 or count=0, out_valid SHALL be all-zero in the following cycle.
REQ-013 Each out_valid SHALL be high for exactly one cycle per record; no record SHALL be duplicated or lost.
REQ-014 out_order SHALL be a 64-bit counter, 0 after reset, assigned consecutively across channels in program order, advancing by n per drain.
REQ-015 Minimum latency SHALL be 2 edges: record written at edge E, visible on out_valid after edge E+1.
REQ-016 Push and pop in the same cycle SHALL be allowed; count_next = count + pushed - popped; pops use pre-edge count only (no same-cycle bypass).
REQ-017 Read and write pointers SHALL wrap modulo DEPTH; full (count=DEPTH) and empty SHALL be distinguished by count.
REQ-018 Drain SHALL normalise records: rd_wdata forced to 0 when rd_addr=0; rs1_rdata/rs2_rdata forced to 0 when their address is 0; all other fields passed unchanged.
REQ-019 Outputs for invalid channels SHALL be driven to 0 (never X).

Reset
REQ-020 Reset SHALL clear pointers, count, order counter, err, and all out_valid/out_order/out_pkt registers to 0.
REQ-021 Reset mid-operation SHALL discard all buffered records; order restarts at 0 on the first post-reset drain.
REQ-022 in_ready SHALL be 0 during the reset cycle.

Structure
REQ-023 rvfi_pkt_t (inst 32, rs1_addr 5, rs2_addr 5, rs1_rdata 32, rs2_rdata 32, rd_addr 5, rd_wdata 32, pc_rdata 32, pc_wdata 32, mem_addr 32, mem_rmask 4, mem_wmask 4, mem_rdata 32, mem_wdata 32) SHALL live in shared package rvfi_pkg, with the ORDER_W=64 constant.
REQ-024 Storage SHALL be one sub-module, rvfi_mwmr_fifo (IN_W write ports, DRAIN_MAX read ports); normalisation and order counting SHALL stay in the top.

Verification
REQ-025 Reset, push 2 records/cycle for 3 cycles, out_stall=0 -> 6 records emitted in order, out_order 0..5, each once.
REQ-026 out_stall=1, push until in_ready=0 -> count=15 or 16 (IN_W=2 stops at count>14), in_ready drops when free<2; release stall -> 8 records on channels 0..7 in one cycle, remainder next cycle.
REQ-027 Simultaneous push of 2 and drain at count=16 with DRAIN_MAX=8 -> count 16->8 only (in_ready=0 blocks push); no loss across pointer wrap over 40 records.
REQ-028 in_valid=2'b10 -> err=1 sticky, count unchanged, no output.
REQ-029 Record with rd_addr=0, rd_wdata=0xDEADBEEF -> out rd_wdata=0; rs1_addr=3, rs1_rdata=0x1234 -> passed unchanged.
REQ-030 Assert rst with 5 buffered records -> next cycle out_valid=0, count=0; new record emits with out_order=0.
